// File: rtl/div_scheduler_pkg.sv
// Shared types and helpers for the divider scheduler.
package div_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sched_state_t;

   // A single requester still needs a one-bit id field.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// Request, response and divider-side signals of the scheduler, bundled as one interface.
interface div_scheduler_if #(
   parameter int N    = 16,
   parameter int NREQ = 4
);
   localparam int ID_W = div_scheduler_pkg::id_width(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_dividend;
   logic [NREQ*N-1:0] req_divisor;
   logic              resp_valid;
   logic              resp_ready;
   logic [ID_W-1:0]   resp_id;
   logic [N-1:0]      resp_q;
   logic [N-1:0]      resp_r;
   logic              resp_exc;
   logic              resp_timeout;
   logic              div_req;
   logic [N-1:0]      div_dividend;
   logic [N-1:0]      div_divisor;
   logic [N-1:0]      div_q;
   logic              div_ready;
   logic              div_exception;

   modport slave (
      input  req_valid, req_dividend, req_divisor, resp_ready,
             div_q, div_ready, div_exception,
      output req_ready, resp_valid, resp_id, resp_q, resp_r, resp_exc, resp_timeout,
             div_req, div_dividend, div_divisor
   );

   modport master (
      output req_valid, req_dividend, req_divisor, resp_ready,
             div_q, div_ready, div_exception,
      input  req_ready, resp_valid, resp_id, resp_q, resp_r, resp_exc, resp_timeout,
             div_req, div_dividend, div_divisor
   );

endinterface

// File: rtl/div_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i and ascends, wrapping.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [ID_W-1:0] idx_o,
   output logic            any_o
);

   int cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(ptr_i) + k) % NREQ;
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/div_scheduler.sv
// Shares one iterative divider among NREQ requesters, one operation in flight.
// state | meaning
// IDLE  | arbitrate, latch winner's operands in the grant cycle
// ISSUE | one-cycle div_req pulse, clear watchdog
// WAIT  | wait for div_ready or watchdog expiry, fix up result
// RESP  | hold response until resp_ready
module div_scheduler
   import div_scheduler_pkg::*;
#(
   parameter int N      = 16,
   parameter int NREQ   = 4,
   parameter int TO_CYC = 64
) (
   input  logic                  clk,
   input  logic                  rstn,
   div_scheduler_if.slave        bus
);

   localparam int ID_W = id_width(NREQ);
   localparam int WD_W = $clog2(TO_CYC);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);

   sched_state_t    state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, id_q, arb_idx;
   logic [NREQ-1:0] arb_gnt;
   logic            arb_any;
   logic [N-1:0]    dividend_q, divisor_q, q_q, r_q, rem_c;
   logic            exc_q, to_q;
   logic [WD_W-1:0] wdog_q;
   logic            grant_fire, wdog_expired;

   rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
      .req_i (bus.req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   assign grant_fire   = (state_q == IDLE) && arb_any;
   assign wdog_expired = (wdog_q == WD_LAST);
   // Remainder only needs the low N bits, so the N-bit truncated product suffices.
   assign rem_c        = dividend_q - bus.div_q * divisor_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arb_any) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (bus.div_ready || wdog_expired) state_d = RESP;
         RESP:    if (bus.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = '0;
      bus.div_req    = 1'b0;
      bus.resp_valid = 1'b0;
      case (state_q)
         IDLE:    bus.req_ready  = arb_gnt;
         ISSUE:   bus.div_req    = 1'b1;
         RESP:    bus.resp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr_q   <= '0;
         id_q       <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         q_q        <= '0;
         r_q        <= '0;
         exc_q      <= 1'b0;
         to_q       <= 1'b0;
         wdog_q     <= '0;
      end else begin
         if (grant_fire) begin
            dividend_q <= bus.req_dividend[int'(arb_idx)*N +: N];
            divisor_q  <= bus.req_divisor[int'(arb_idx)*N +: N];
            id_q       <= arb_idx;
            rr_ptr_q   <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
         end
         if (state_q == ISSUE) wdog_q <= '0;
         if (state_q == WAIT) begin
            wdog_q <= wdog_q + 1'b1;
            if (bus.div_ready) begin
               to_q <= 1'b0;
               if (bus.div_exception) begin
                  q_q   <= '1;
                  r_q   <= dividend_q;
                  exc_q <= 1'b1;
               end else begin
                  q_q   <= bus.div_q;
                  r_q   <= rem_c;
                  exc_q <= 1'b0;
               end
            end else if (wdog_expired) begin
               q_q   <= '1;
               r_q   <= '1;
               exc_q <= 1'b0;
               to_q  <= 1'b1;
            end
         end
      end
   end

   assign bus.resp_id      = id_q;
   assign bus.resp_q       = q_q;
   assign bus.resp_r       = r_q;
   assign bus.resp_exc     = exc_q;
   assign bus.resp_timeout = to_q;
   assign bus.div_dividend = dividend_q;
   assign bus.div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler with an attached multi-cycle divider model and a round-robin reference.
module tb_div_scheduler;

   localparam int N       = 16;
   localparam int NREQ    = 4;
   localparam int TO_CYC  = 64;
   localparam int DIV_LAT = 2*N + 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   div_scheduler_if #(.N(N), .NREQ(NREQ)) bus ();

   div_scheduler #(.N(N), .NREQ(NREQ), .TO_CYC(TO_CYC)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   logic [NREQ-1:0] req_valid = '0;
   logic            resp_ready = 1'b0;
   logic [N-1:0]    a [NREQ];
   logic [N-1:0]    b [NREQ];

   assign bus.req_valid    = req_valid;
   assign bus.resp_ready   = resp_ready;
   assign bus.req_dividend = {a[3], a[2], a[1], a[0]};
   assign bus.req_divisor  = {b[3], b[2], b[1], b[0]};

   // divider model: fixed latency, ready stays high after completion until the next req
   logic         dv_ready, dv_exc, dv_busy;
   logic [N-1:0] dv_q;
   int           dv_cnt;
   bit           stub = 0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dv_ready <= 1'b0; dv_exc <= 1'b0; dv_busy <= 1'b0; dv_q <= '0; dv_cnt <= 0;
      end else if (bus.div_req) begin
         dv_ready <= 1'b0;
         dv_busy  <= 1'b1;
         dv_cnt   <= DIV_LAT;
         dv_exc   <= (bus.div_divisor == 0);
         dv_q     <= (bus.div_divisor == 0) ? '1 : bus.div_dividend / bus.div_divisor;
      end else if (dv_busy && !stub) begin
         dv_cnt <= dv_cnt - 1;
         if (dv_cnt == 1) begin
            dv_ready <= 1'b1;
            dv_busy  <= 1'b0;
         end
      end
   end

   assign bus.div_q         = dv_q;
   assign bus.div_ready     = dv_ready;
   assign bus.div_exception = dv_exc;

   int n_cmp = 0;
   int n_fail = 0;
   int dreq_cnt = 0;
   int rr_ptr_m = 0;

   always @(posedge clk) if (rstn && bus.div_req) dreq_cnt++;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic apply_reset();
      req_valid  = '0;
      resp_ready = 1'b0;
      rstn       = 1'b0;
      repeat (3) @(negedge clk);
      rstn     = 1'b1;
      rr_ptr_m = 0;
      @(negedge clk);
   endtask

   task automatic wait_grant(output bit ok, output int idx, output logic [NREQ-1:0] gvec);
      ok = 0; idx = -1; gvec = '0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (bus.req_ready != '0) begin
            gvec = bus.req_ready;
            for (int k = 0; k < NREQ; k++) if (gvec[k]) idx = k;
            ok = 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_resp(output bit ok, output int c, output int rid,
                            output logic [N-1:0] rq, output logic [N-1:0] rr,
                            output logic rexc, output logic rto);
      ok = 0; c = 0; rid = -1; rq = '0; rr = '0; rexc = 1'b0; rto = 1'b0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (bus.resp_valid) begin
            rid = int'(bus.resp_id); rq = bus.resp_q; rr = bus.resp_r;
            rexc = bus.resp_exc; rto = bus.resp_timeout;
            ok = 1;
            break;
         end
         @(negedge clk);
         c++;
      end
   endtask

   // Drives one operation from grant to accepted response; returns what was observed.
   task automatic run_op(input bit drop, input int hold,
                         output bit gok, output int gidx, output logic [NREQ-1:0] gvec,
                         output logic [N-1:0] ea, output logic [N-1:0] eb,
                         output bit rok, output int lat, output int rid,
                         output logic [N-1:0] rq, output logic [N-1:0] rr,
                         output logic rexc, output logic rto);
      int c;
      ea = '0; eb = '0; rok = 0; lat = 0; rid = -1; rq = '0; rr = '0; rexc = 1'b0; rto = 1'b0;
      wait_grant(gok, gidx, gvec);
      if (!gok) return;
      ea = a[gidx];
      eb = b[gidx];
      rr_ptr_m = (gidx + 1) % NREQ;
      if (drop) req_valid = '0;
      wait_resp(rok, c, rid, rq, rr, rexc, rto);
      lat = 1 + c;
      if (!rok) return;
      repeat (hold) @(negedge clk);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [3*N+NREQ+3-1:0] outs;
      rstn = 1'b0;
      req_valid = '0;
      for (int k = 0; k < NREQ; k++) begin a[k] = '0; b[k] = '0; end
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({bus.req_ready, bus.resp_valid, bus.div_req} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: req_ready=%b resp_valid=%b div_req=%b required all 0",
                  bus.req_ready, bus.resp_valid, bus.div_req);
      end
      outs = {bus.resp_q, bus.resp_r, bus.div_dividend, 1'b0, bus.resp_exc, bus.resp_timeout,
              bus.div_divisor[NREQ-1:0]};
      n_cmp++;
      if (outs !== '0 || bus.resp_id !== '0 || bus.div_divisor !== '0) begin
         n_fail++;
         $display("FAIL reset_data: q=%h r=%h id=%0d exc=%b to=%b dd=%h ds=%h required 0",
                  bus.resp_q, bus.resp_r, bus.resp_id, bus.resp_exc, bus.resp_timeout,
                  bus.div_dividend, bus.div_divisor);
      end
      rstn = 1'b1;
      rr_ptr_m = 0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit gok, rok; int gidx, lat, rid, d0;
      logic [NREQ-1:0] gvec; logic [N-1:0] ea, eb, rq, rr; logic rexc, rto;
      a[0] = 16'd100; b[0] = 16'd7;
      d0 = dreq_cnt;
      req_valid = 4'b0001;
      run_op(1, 0, gok, gidx, gvec, ea, eb, rok, lat, rid, rq, rr, rexc, rto);
      n_cmp++;
      if (!gok || gvec !== 4'b0001) begin
         n_fail++; $display("FAIL basic_grant: req_ready=%b required 0001", gvec);
      end
      n_cmp++;
      if (!rok || rid !== 0 || rq !== 16'd14 || rr !== 16'd2 || rexc !== 1'b0 || rto !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_resp: id=%0d q=%0d r=%0d exc=%b to=%b required id=0 q=14 r=2 exc=0 to=0",
                  rid, rq, rr, rexc, rto);
      end
      n_cmp++;
      if (dreq_cnt - d0 !== 1) begin
         n_fail++; $display("FAIL basic_div_req: pulses=%0d required 1", dreq_cnt - d0);
      end
   endtask

   task automatic test_div_zero();
      bit gok, rok; int gidx, lat, rid;
      logic [NREQ-1:0] gvec; logic [N-1:0] ea, eb, rq, rr; logic rexc, rto;
      a[1] = 16'd500; b[1] = 16'd0;
      req_valid = 4'b0010;
      run_op(1, 0, gok, gidx, gvec, ea, eb, rok, lat, rid, rq, rr, rexc, rto);
      n_cmp++;
      if (!rok || rid !== 1 || rq !== 16'hFFFF || rr !== 16'd500 || rexc !== 1'b1 || rto !== 1'b0) begin
         n_fail++;
         $display("FAIL div_zero: id=%0d q=%h r=%0d exc=%b to=%b required id=1 q=ffff r=500 exc=1 to=0",
                  rid, rq, rr, rexc, rto);
      end
   endtask

   task automatic test_rr_order();
      bit gok, rok; int gidx, lat, rid;
      logic [NREQ-1:0] gvec; logic [N-1:0] ea, eb, rq, rr; logic rexc, rto;
      int exp_order [7] = '{0, 2, 3, 0, 1, 2, 3};
      apply_reset();
      for (int k = 0; k < NREQ; k++) begin a[k] = N'($urandom); b[k] = N'($urandom_range(1, 300)); end
      req_valid = 4'b0101;
      for (int i = 0; i < 7; i++) begin
         if (i == 2) req_valid = 4'b1111;
         run_op(0, 0, gok, gidx, gvec, ea, eb, rok, lat, rid, rq, rr, rexc, rto);
         n_cmp++;
         if (!gok || gidx !== exp_order[i] || gvec !== NREQ'(1 << exp_order[i])) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: req_ready=%b required one-hot of %0d", i, gvec, exp_order[i]);
         end
         n_cmp++;
         if (!rok || rid !== exp_order[i] || rq !== ea / eb || rr !== ea % eb || rexc !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_resp[%0d]: id=%0d q=%0d r=%0d required id=%0d q=%0d r=%0d",
                     i, rid, rq, rr, exp_order[i], ea / eb, ea % eb);
         end
         if (gok) begin a[gidx] = N'($urandom); b[gidx] = N'($urandom_range(1, 300)); end
      end
   endtask

   task automatic test_backpressure();
      bit gok, rok, bad; int gidx, c, rid, expw;
      logic [NREQ-1:0] gvec; logic [N-1:0] ea, eb, rq, rr; logic rexc, rto;
      req_valid = 4'b1111;
      expw = rr_pick(req_valid, rr_ptr_m);
      wait_grant(gok, gidx, gvec);
      ea = (gok) ? a[gidx] : '0;
      eb = (gok) ? b[gidx] : '0;
      if (gok) rr_ptr_m = (gidx + 1) % NREQ;
      wait_resp(rok, c, rid, rq, rr, rexc, rto);
      n_cmp++;
      if (!rok || rid !== expw || rq !== ea / eb || rr !== ea % eb) begin
         n_fail++;
         $display("FAIL bp_resp: id=%0d q=%0d r=%0d required id=%0d q=%0d r=%0d",
                  rid, rq, rr, expw, ea / eb, ea % eb);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (bus.resp_valid !== 1'b1 || int'(bus.resp_id) !== rid || bus.resp_q !== rq ||
             bus.resp_r !== rr || bus.resp_exc !== rexc || bus.resp_timeout !== rto ||
             bus.req_ready !== '0 || bus.div_req !== 1'b0) bad = 1;
      end
      n_cmp++;
      if (bad) begin
         n_fail++; $display("FAIL bp_stable: held response changed or new grant/div_req seen, required stable");
      end
      req_valid = '0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      n_cmp++;
      if (bus.resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_release: resp_valid=%b required 0", bus.resp_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit gok, rok, seen; int gidx, lat, rid;
      logic [NREQ-1:0] gvec; logic [N-1:0] ea, eb, rq, rr; logic rexc, rto;
      a[1] = 16'd1234; b[1] = 16'd11;
      req_valid = 4'b0010;
      wait_grant(gok, gidx, gvec);
      req_valid = '0;
      repeat (5) @(negedge clk);
      rstn = 1'b0;
      #1;
      n_cmp++;
      if (bus.req_ready !== '0 || bus.resp_valid !== 1'b0 || bus.div_req !== 1'b0 ||
          bus.resp_q !== '0 || bus.resp_r !== '0 || bus.resp_id !== '0 ||
          bus.resp_exc !== 1'b0 || bus.resp_timeout !== 1'b0 ||
          bus.div_dividend !== '0 || bus.div_divisor !== '0) begin
         n_fail++;
         $display("FAIL midreset_outs: rr=%b rv=%b dr=%b q=%h r=%h dd=%h ds=%h required all 0",
                  bus.req_ready, bus.resp_valid, bus.div_req, bus.resp_q, bus.resp_r,
                  bus.div_dividend, bus.div_divisor);
      end
      @(negedge clk);
      rstn = 1'b1;
      rr_ptr_m = 0;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (bus.resp_valid) seen = 1;
      end
      n_cmp++;
      if (seen) begin
         n_fail++; $display("FAIL midreset_drop: resp_valid=1 seen for dropped op, required none");
      end
      a[2] = 16'd9; b[2] = 16'd3;
      req_valid = 4'b0100;
      run_op(1, 1, gok, gidx, gvec, ea, eb, rok, lat, rid, rq, rr, rexc, rto);
      n_cmp++;
      if (!rok || rid !== 2 || rq !== 16'd3 || rr !== 16'd0 || rexc !== 1'b0 || rto !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_fresh: id=%0d q=%0d r=%0d exc=%b to=%b required id=2 q=3 r=0",
                  rid, rq, rr, rexc, rto);
      end
   endtask

   task automatic test_random();
      bit gok, rok; int gidx, lat, rid, expw;
      logic [NREQ-1:0] gvec, mask; logic [N-1:0] ea, eb, rq, rr, eq, er; logic rexc, rto, eexc;
      for (int i = 0; i < 30; i++) begin
         for (int k = 0; k < NREQ; k++) begin
            a[k] = N'($urandom);
            b[k] = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 65535));
         end
         mask = NREQ'($urandom_range(1, 15));
         expw = rr_pick(mask, rr_ptr_m);
         req_valid = mask;
         run_op(1, $urandom_range(0, 3), gok, gidx, gvec, ea, eb, rok, lat, rid, rq, rr, rexc, rto);
         n_cmp++;
         if (!gok || gidx !== expw || gvec !== NREQ'(1 << expw)) begin
            n_fail++;
            $display("FAIL rand_grant[%0d]: mask=%b req_ready=%b required winner %0d", i, mask, gvec, expw);
         end
         eexc = (eb == 0);
         eq   = eexc ? '1 : ea / eb;
         er   = eexc ? ea : ea % eb;
         n_cmp++;
         if (!rok || rid !== expw || rq !== eq || rr !== er || rexc !== eexc || rto !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_resp[%0d]: id=%0d q=%h r=%h exc=%b to=%b required id=%0d q=%h r=%h exc=%b to=0",
                     i, rid, rq, rr, rexc, rto, expw, eq, er, eexc);
         end
      end
   endtask

   task automatic test_timeout();
      bit gok, rok; int gidx, lat, rid;
      logic [NREQ-1:0] gvec; logic [N-1:0] ea, eb, rq, rr; logic rexc, rto;
      stub = 1;
      a[3] = 16'd77; b[3] = 16'd5;
      req_valid = 4'b1000;
      run_op(1, 0, gok, gidx, gvec, ea, eb, rok, lat, rid, rq, rr, rexc, rto);
      n_cmp++;
      if (!rok || rid !== 3 || rq !== 16'hFFFF || rr !== 16'hFFFF || rto !== 1'b1 || rexc !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_resp: id=%0d q=%h r=%h exc=%b to=%b required id=3 q=ffff r=ffff exc=0 to=1",
                  rid, rq, rr, rexc, rto);
      end
      n_cmp++;
      if (lat !== TO_CYC + 2) begin
         n_fail++; $display("FAIL timeout_latency: grant-to-resp=%0d required %0d", lat, TO_CYC + 2);
      end
      stub = 0;
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_rr_order();
      test_backpressure();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
